// File: rtl/psdsqrt_seq.sv
// Sequential integer square root: floor(sqrt(xin)) by bit-serial successive approximation.
// Optional remainder output enabled by defining PSDSQRT_REM_EN.
module psdsqrt_seq #(
    parameter int unsigned NBITSIN = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NBITSIN-1:0]   xin,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
`ifdef PSDSQRT_REM_EN
    output logic [NBITSIN/2:0]   rem,
`endif
    output logic [NBITSIN/2-1:0] sqrt
);
    localparam int unsigned NBITSOUT = NBITSIN / 2;
    localparam int unsigned NITER = NBITSOUT;
    localparam logic [NBITSOUT-1:0] MaskInit = NBITSOUT'(1) << (NITER - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e              state_q, state_d;
    logic [NBITSIN-1:0]  xop_q, xop_d;
    logic [NBITSOUT-1:0] trial_q, trial_d;
    logic [NBITSOUT-1:0] mask_q, mask_d;
    logic [NBITSOUT-1:0] sqrt_q, sqrt_d;
    logic [NBITSOUT-1:0] test;
    logic [NBITSOUT-1:0] trial_next;
    logic [NBITSIN-1:0]  test_sq;
`ifdef PSDSQRT_REM_EN
    logic [NBITSOUT:0]   rem_q, rem_d;
    logic [NBITSIN-1:0]  fin_sq;
`endif

    // Full-width square so the compare never truncates.
    assign test       = trial_q | mask_q;
    assign test_sq    = NBITSIN'(test) * NBITSIN'(test);
    assign trial_next = (xop_q >= test_sq) ? test : trial_q;
`ifdef PSDSQRT_REM_EN
    assign fin_sq     = NBITSIN'(trial_next) * NBITSIN'(trial_next);
`endif

    always_comb begin
        state_d = state_q;
        xop_d   = xop_q;
        trial_d = trial_q;
        mask_d  = mask_q;
        sqrt_d  = sqrt_q;
`ifdef PSDSQRT_REM_EN
        rem_d   = rem_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    state_d = StBusy;
                    xop_d   = xin;
                    trial_d = '0;
                    mask_d  = MaskInit;
                end
            end
            StBusy: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    trial_d = trial_next;
                    mask_d  = mask_q >> 1;
                    // mask bit 0 marks the final iteration
                    if (mask_q[0]) begin
                        state_d = StDone;
                        sqrt_d  = trial_next;
`ifdef PSDSQRT_REM_EN
                        rem_d   = (NBITSOUT + 1)'(xop_q - fin_sq);
`endif
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            xop_q   <= '0;
            trial_q <= '0;
            mask_q  <= '0;
            sqrt_q  <= '0;
`ifdef PSDSQRT_REM_EN
            rem_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            xop_q   <= xop_d;
            trial_q <= trial_d;
            mask_q  <= mask_d;
            sqrt_q  <= sqrt_d;
`ifdef PSDSQRT_REM_EN
            rem_q   <= rem_d;
`endif
        end
    end

    assign ready = (state_q == StIdle) || (state_q == StDone);
    assign busy  = (state_q == StBusy);
    assign done  = (state_q == StDone);
    assign sqrt  = sqrt_q;
`ifdef PSDSQRT_REM_EN
    assign rem   = rem_q;
`endif

endmodule

// File: tb/tb_psdsqrt_seq.sv
// Self-checking bench for psdsqrt_seq: 32-bit vector table, corner sequences, random jobs,
// and an exhaustive 8-bit instance. Remainder checks active when PSDSQRT_REM_EN is defined.
module tb_psdsqrt_seq;
    logic        clock = 1'b0;
    logic        reset, start, abort, start8;
    logic [31:0] xin;
    logic [7:0]  xin8;
    logic        ready, busy, done, ready8, busy8, done8;
    logic [15:0] sqrt;
    logic [3:0]  sqrt8;
`ifdef PSDSQRT_REM_EN
    logic [16:0] rem;
    logic [4:0]  rem8;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    psdsqrt_seq #(.NBITSIN(32)) u_dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort), .xin(xin),
        .ready(ready), .busy(busy), .done(done),
`ifdef PSDSQRT_REM_EN
        .rem(rem),
`endif
        .sqrt(sqrt)
    );

    psdsqrt_seq #(.NBITSIN(8)) u_dut8 (
        .clock(clock), .reset(reset), .start(start8), .abort(1'b0), .xin(xin8),
        .ready(ready8), .busy(busy8), .done(done8),
`ifdef PSDSQRT_REM_EN
        .rem(rem8),
`endif
        .sqrt(sqrt8)
    );

    typedef struct {
        logic [31:0] x;
        logic [15:0] exp_sqrt;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: floating-point estimate corrected with exact integer arithmetic.
    function automatic longint ref_sqrt(input longint x);
        longint r;
        r = longint'($floor($sqrt(real'(x))));
        while (r * r > x) r--;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    // Starts a job in the current cycle; returns cycles until done (-1 on timeout).
    task automatic job32(input logic [31:0] x, output int lat);
        start = 1'b1;
        xin   = x;
        lat   = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock); #1;
            start = 1'b0;
            abort = 1'b0;
            xin   = $urandom;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic job8(input logic [7:0] x, output int lat);
        start8 = 1'b1;
        xin8   = x;
        lat    = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock); #1;
            start8 = 1'b0;
            xin8   = 8'($urandom);
            if (done8) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic check32(input string name, input logic [31:0] x, input int lat);
        longint s;
        s = ref_sqrt(longint'(x));
        chk({name, " latency"}, 64'(lat), 64'd17);
        chk({name, " sqrt"}, 64'(sqrt), 64'(s));
`ifdef PSDSQRT_REM_EN
        chk({name, " rem"}, 64'(rem), 64'(longint'(x) - s * s));
`endif
    endtask

    task automatic no_done_for(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clock); #1;
            if (done) seen++;
        end
        chk(name, 64'(seen), 64'd0);
    endtask

    initial begin
        vec_t vecs[$];
        int   lat;
        logic [31:0] x;
        int unsigned kk;

        vecs.push_back('{32'd0, 16'd0});
        vecs.push_back('{32'd1, 16'd1});
        vecs.push_back('{32'd3, 16'd1});
        vecs.push_back('{32'd4, 16'd2});
        vecs.push_back('{32'd15, 16'd3});
        vecs.push_back('{32'd16, 16'd4});
        vecs.push_back('{32'd143, 16'd11});
        vecs.push_back('{32'd144, 16'd12});
        vecs.push_back('{32'd1000000, 16'd1000});
        vecs.push_back('{32'hFFFE_0000, 16'hFFFE});
        vecs.push_back('{32'hFFFE_0001, 16'hFFFF});
        vecs.push_back('{32'hFFFF_FFFF, 16'hFFFF});

        reset = 1'b1; start = 1'b0; abort = 1'b0; xin = '0;
        start8 = 1'b0; xin8 = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        chk("reset ready", 64'(ready), 64'd1);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset sqrt", 64'(sqrt), 64'd0);
        chk("reset ready8", 64'(ready8), 64'd1);
        chk("reset sqrt8", 64'(sqrt8), 64'd0);
`ifdef PSDSQRT_REM_EN
        chk("reset rem", 64'(rem), 64'd0);
`endif

        // Table of fixed vectors, each from idle.
        foreach (vecs[i]) begin
            job32(vecs[i].x, lat);
            chk("table latency", 64'(lat), 64'd17);
            chk("table sqrt", 64'(sqrt), 64'(vecs[i].exp_sqrt));
`ifdef PSDSQRT_REM_EN
            chk("table rem", 64'(rem), 64'(longint'(vecs[i].x) - longint'(vecs[i].exp_sqrt) ** 2));
`endif
            @(posedge clock); #1;
            chk("table idle ready", 64'(ready), 64'd1);
        end

        // Back-to-back: second start (with abort) issued in the DONE cycle.
        job32(32'd0, lat);
        check32("b2b first", 32'd0, lat);
        chk("b2b done pulse", 64'(done), 64'd1);
        abort = 1'b1;
        job32(32'd1, lat);
        check32("b2b second", 32'd1, lat);

        // Start while busy is ignored.
        @(posedge clock); #1;
        start = 1'b1; xin = 32'd144;
        @(posedge clock); #1;
        start = 1'b0; xin = 32'd7;
        chk("busy after start", 64'(busy), 64'd1);
        @(posedge clock); #1;
        start = 1'b1; xin = 32'd9;
        lat = -1;
        for (int k = 3; k <= 40; k++) begin
            @(posedge clock); #1;
            start = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
        end
        check32("ignored start", 32'd144, lat);

        // Abort mid-job keeps the previous result.
        @(posedge clock); #1;
        start = 1'b1; xin = 32'd143;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1 abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        chk("abort ready", 64'(ready), 64'd1);
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort sqrt held", 64'(sqrt), 64'd12);
        no_done_for("abort no done", 25);

        // Synchronous reset mid-job.
        start = 1'b1; xin = 32'd1000000;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("midreset ready", 64'(ready), 64'd1);
        chk("midreset busy", 64'(busy), 64'd0);
        chk("midreset sqrt", 64'(sqrt), 64'd0);
        no_done_for("midreset no done", 25);

        // Randomised jobs, biased toward squares and square-minus-one.
        for (int i = 0; i < 40; i++) begin
            kk = $urandom_range(1, 65535);
            case (i % 3)
                0: x = $urandom;
                1: x = 32'(kk * kk);
                default: x = 32'(kk * kk - 1);
            endcase
            job32(x, lat);
            check32("random", x, lat);
        end

        // Exhaustive 8-bit, back-to-back jobs.
        for (int v = 0; v < 256; v++) begin
            job8(8'(v), lat);
            chk("w8 latency", 64'(lat), 64'd5);
            chk("w8 sqrt", 64'(sqrt8), 64'(ref_sqrt(longint'(v))));
`ifdef PSDSQRT_REM_EN
            chk("w8 rem", 64'(rem8), 64'(longint'(v) - ref_sqrt(longint'(v)) ** 2));
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
